// File: rtl/grad_step_if.sv
// grad_step_if: handshake and data bundle for the grad_step_update stage.
//   Upstream side : in_valid, in_ready, pos_in[63:0], grad_in[63:0]
//   Downstream side: out_valid, out_ready, pos_out[63:0], converged, iter_count[7:0]
// Four signed 8.8 lanes per 64-bit vector: dim0 = [15:0] ... dim3 = [63:48].
// master: the environment that feeds vectors in and takes results out.
// slave : the grad_step_update block itself.
interface grad_step_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pos_in;
  logic [63:0] grad_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pos_out;
  logic        converged;
  logic [7:0]  iter_count;

  modport master (
    output in_valid, pos_in, grad_in, out_ready,
    input  in_ready, out_valid, pos_out, converged, iter_count
  );

  modport slave (
    input  in_valid, pos_in, grad_in, out_ready,
    output in_ready, out_valid, pos_out, converged, iter_count
  );
endinterface

// File: rtl/grad_step_update.sv
// grad_step_update: one gradient-descent position step for a 4D vector.
// Each lane computes pos - (grad >>> LR_SHIFT), saturated to signed 8.8, using
// one shared subtract/saturate unit that walks dims 0..3 on consecutive cycles.
// Ports:
//   clk  - single rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - grad_step_if.slave (input vector handshake, result handshake,
//          convergence flag, saturating handshake counter)
// Parameters:
//   LR_SHIFT    - learning rate exponent (1..8)
//   CONV_THRESH - 8.8 magnitude; |step| at or below it counts as converged
module grad_step_update #(
  parameter int          LR_SHIFT    = 4,
  parameter logic [15:0] CONV_THRESH = 16'h0004
) (
  input  logic        clk,
  input  logic        rst,
  grad_step_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  idx_r;
  logic [63:0] pos_lat_r;
  logic [63:0] grad_lat_r;
  logic [63:0] pos_out_r;
  logic        conv_acc_r;
  logic        converged_r;
  logic [7:0]  iter_count_r;

  logic [15:0] pos_lane_s;
  logic [15:0] grad_lane_s;
  logic [15:0] step_s;
  logic [16:0] diff_s;
  logic [15:0] result_s;
  logic        step_ok_s;

  // Clamp a 17-bit signed difference into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic [16:0] d);
    logic [15:0] r;
    case (d[16:15])
      2'b01:   r = 16'h7FFF;
      2'b10:   r = 16'h8000;
      default: r = d[15:0];
    endcase
    return r;
  endfunction

  // Magnitude of a signed 16-bit value at 17 bits so -32768 cannot overflow.
  function automatic logic [16:0] abs17(input logic [15:0] s);
    logic [16:0] e;
    logic [16:0] r;
    e = {s[15], s};
    if (e[16]) begin
      r = 17'd0 - e;
    end else begin
      r = e;
    end
    return r;
  endfunction

  // Select the current lane and run the shared shift/subtract/saturate unit.
  always_comb begin
    pos_lane_s  = 16'h0000;
    grad_lane_s = 16'h0000;
    case (idx_r)
      2'd0: begin pos_lane_s = pos_lat_r[15:0];  grad_lane_s = grad_lat_r[15:0];  end
      2'd1: begin pos_lane_s = pos_lat_r[31:16]; grad_lane_s = grad_lat_r[31:16]; end
      2'd2: begin pos_lane_s = pos_lat_r[47:32]; grad_lane_s = grad_lat_r[47:32]; end
      2'd3: begin pos_lane_s = pos_lat_r[63:48]; grad_lane_s = grad_lat_r[63:48]; end
      default: begin pos_lane_s = 16'h0000; grad_lane_s = 16'h0000; end
    endcase
    step_s    = $signed(grad_lane_s) >>> LR_SHIFT;
    diff_s    = {pos_lane_s[15], pos_lane_s} - {step_s[15], step_s};
    result_s  = sat16(diff_s);
    step_ok_s = (abs17(step_s) <= {1'b0, CONV_THRESH});
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == 2'd3) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = CALC;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input latch, lane write-back, convergence accumulation and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= 2'd0;
      pos_lat_r    <= 64'h0;
      grad_lat_r   <= 64'h0;
      pos_out_r    <= 64'h0;
      conv_acc_r   <= 1'b0;
      converged_r  <= 1'b0;
      iter_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            pos_lat_r  <= bus.pos_in;
            grad_lat_r <= bus.grad_in;
            idx_r      <= 2'd0;
            conv_acc_r <= 1'b1;
          end
        end
        CALC: begin
          idx_r      <= idx_r + 2'd1;
          conv_acc_r <= conv_acc_r & step_ok_s;
          case (idx_r)
            2'd0:    pos_out_r[15:0]  <= result_s;
            2'd1:    pos_out_r[31:16] <= result_s;
            2'd2:    pos_out_r[47:32] <= result_s;
            2'd3:    pos_out_r[63:48] <= result_s;
            default: pos_out_r        <= pos_out_r;
          endcase
          // The last lane's verdict is folded in directly as HOLD is entered.
          if (idx_r == 2'd3) begin
            converged_r <= conv_acc_r & step_ok_s;
          end
        end
        HOLD: begin
          if (bus.out_ready && (iter_count_r != 8'hFF)) begin
            iter_count_r <= iter_count_r + 8'd1;
          end
        end
        default: idx_r <= 2'd0;
      endcase
    end
  end

  assign bus.in_ready   = (state_r == IDLE);
  assign bus.out_valid  = (state_r == HOLD);
  assign bus.pos_out    = pos_out_r;
  assign bus.converged  = converged_r;
  assign bus.iter_count = iter_count_r;

endmodule
